// File: rtl/gate_cursor_ctrl.sv
// gate_cursor_ctrl
//   Turns four raw push buttons into cursor moves over an 18-position gate
//   grid: two rows of eight (1..8, 9..16) plus a short row of two (17, 18).
//   Each button is synchronised and debounced. A debounced press produces a
//   one-cycle pulse. Simultaneous pulses resolve with priority U > D > L > R.
//   The winning pulse moves the registered cursor.
//
//   Optional feature: define GATE_CURSOR_HOLD_REPEAT_EN to enable hold-to-repeat.
//   A held button re-pulses REPEAT_DELAY cycles after its first pulse. It then
//   re-pulses every REPEAT_PERIOD cycles until the button is released.
//
// Ports
//   clk          system clock, every flop on its rising edge
//   reset        synchronous active-high reset
//   btn[3:0]     raw buttons {U, D, L, R}
//   btn_pulse    accepted one-cycle move pulse, same bit order as btn
//   gate_select  cursor position, legal values 1..18
//   move_valid   one-cycle strobe when gate_select changed
module gate_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] btn_pulse,
  output logic [4:0] gate_select,
  output logic       move_valid
);

  localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_q, deb_d, debPrev_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic [3:0]      rise, fire;
  logic [3:0]      pulseRaw_q, pulseRaw_d;
  logic [3:0]      accepted;
  logic [4:0]      gate_q, gate_d;
  logic            moveValid_q, moveValid_d;

  // Cursor move table. Any illegal current position recovers to 1.
  function automatic logic [4:0] nextPos(input logic [4:0] cur, input logic [3:0] dir);
    logic [4:0] res;
    res = cur;
    if (cur == 5'd0 || cur > 5'd18) begin
      res = 5'd1;
    end else if (dir[3]) begin
      if (cur == 5'd17)      res = 5'd10;
      else if (cur == 5'd18) res = 5'd15;
      else if (cur >= 5'd9)  res = cur - 5'd8;
    end else if (dir[2]) begin
      if (cur >= 5'd17)      res = cur;
      else if (cur >= 5'd13) res = 5'd18;
      else if (cur >= 5'd9)  res = 5'd17;
      else                   res = cur + 5'd8;
    end else if (dir[1]) begin
      if (cur == 5'd1)       res = 5'd8;
      else if (cur == 5'd9)  res = 5'd16;
      else if (cur == 5'd17) res = 5'd18;
      else                   res = cur - 5'd1;
    end else if (dir[0]) begin
      if (cur == 5'd8)       res = 5'd1;
      else if (cur == 5'd16) res = 5'd9;
      else if (cur == 5'd18) res = 5'd17;
      else                   res = cur + 5'd1;
    end
    return res;
  endfunction

  // The stable-cycle counter restarts whenever the synchronised level agrees
  // with the debounced one, so only an unbroken run of disagreement flips it.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else                                        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = deb_q & ~debPrev_q;

`ifdef GATE_CURSOR_HOLD_REPEAT_EN
  localparam int RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  logic [RptW-1:0] rptCnt_q [4];
  logic [RptW-1:0] rptCnt_d [4];
  logic [3:0]      rptArmed_q, rptArmed_d, rptPeriodic_q, rptPeriodic_d;

  // The repeat counter starts on the cycle the first pulse is registered. It
  // waits the initial delay once and then waits the shorter period after each
  // repeat. Release clears the counter and disarms the repeat.
  always_comb begin
    rptArmed_d    = rptArmed_q;
    rptPeriodic_d = rptPeriodic_q;
    fire          = '0;
    for (int i = 0; i < 4; i++) begin
      rptCnt_d[i] = rptCnt_q[i];
      if (!deb_q[i]) begin
        rptCnt_d[i]      = '0;
        rptArmed_d[i]    = 1'b0;
        rptPeriodic_d[i] = 1'b0;
      end else if (rise[i]) begin
        rptCnt_d[i]      = '0;
        rptArmed_d[i]    = 1'b1;
        rptPeriodic_d[i] = 1'b0;
      end else if (rptArmed_q[i]) begin
        if (rptCnt_q[i] == (rptPeriodic_q[i] ? RptW'(REPEAT_PERIOD - 1)
                                             : RptW'(REPEAT_DELAY - 1))) begin
          fire[i]          = 1'b1;
          rptCnt_d[i]      = '0;
          rptPeriodic_d[i] = 1'b1;
        end else begin
          rptCnt_d[i] = rptCnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptArmed_q    <= '0;
      rptPeriodic_q <= '0;
      for (int i = 0; i < 4; i++) rptCnt_q[i] <= '0;
    end else begin
      rptArmed_q    <= rptArmed_d;
      rptPeriodic_q <= rptPeriodic_d;
      for (int i = 0; i < 4; i++) rptCnt_q[i] <= rptCnt_d[i];
    end
  end
`else
  // Repeat parameters have no effect in this build. They are folded into a
  // constant so they are still referenced.
  logic unusedRepeatCfg;
  assign unusedRepeatCfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign fire = '0;
`endif

  assign pulseRaw_d = rise | fire;

  // Only the highest-priority pulse survives. Losers are discarded.
  always_comb begin
    accepted = 4'b0000;
    if (pulseRaw_q[3])      accepted = 4'b1000;
    else if (pulseRaw_q[2]) accepted = 4'b0100;
    else if (pulseRaw_q[1]) accepted = 4'b0010;
    else if (pulseRaw_q[0]) accepted = 4'b0001;
  end

  // The cursor is updated at the end of the pulse cycle. The strobe is raised
  // only when the position actually changes, so a blocked move gives no strobe.
  always_comb begin
    gate_d      = gate_q;
    moveValid_d = 1'b0;
    if (|accepted) begin
      gate_d      = nextPos(gate_q, accepted);
      moveValid_d = (gate_d != gate_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      debPrev_q   <= '0;
      pulseRaw_q  <= '0;
      gate_q      <= 5'd1;
      moveValid_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      debPrev_q   <= deb_q;
      pulseRaw_q  <= pulseRaw_d;
      gate_q      <= gate_d;
      moveValid_q <= moveValid_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_pulse   = accepted;
  assign gate_select = gate_q;
  assign move_valid  = moveValid_q;

endmodule

// File: tb/tb_gate_cursor_ctrl.sv
// Directed testbench for gate_cursor_ctrl.
// It uses short debounce and repeat settings so that each scenario completes
// within a few dozen cycles.
module tb_gate_cursor_ctrl;

  localparam int DebCycles = 4;
  localparam int RptDelay  = 10;
  localparam int RptPeriod = 3;

  localparam logic [3:0] BtnR = 4'b0001;
  localparam logic [3:0] BtnL = 4'b0010;
  localparam logic [3:0] BtnD = 4'b0100;
  localparam logic [3:0] BtnU = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] btn_pulse;
  logic [4:0] gate_select;
  logic       move_valid;

  int compared   = 0;
  int mismatched = 0;

  int pulseCount [4];
  int moveCount;
  int cycleIdx;
  int firstPulse;
  int firstMove;
  int multiHot;
  int nPulse;
  int pulseAt [16];

  gate_cursor_ctrl #(
    .DEBOUNCE_CYCLES(DebCycles),
    .REPEAT_DELAY   (RptDelay),
    .REPEAT_PERIOD  (RptPeriod)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .btn_pulse  (btn_pulse),
    .gate_select(gate_select),
    .move_valid (move_valid)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reset all of the activity counters that runCycles accumulates.
  task automatic clearStats();
    for (int b = 0; b < 4; b++) pulseCount[b] = 0;
    moveCount  = 0;
    cycleIdx   = 0;
    firstPulse = -1;
    firstMove  = -1;
    multiHot   = 0;
    nPulse     = 0;
  endtask

  // Advance n clocks. Outputs are sampled 1 ns after each rising edge and
  // their activity is accumulated.
  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      cycleIdx++;
      for (int b = 0; b < 4; b++) if (btn_pulse[b]) pulseCount[b]++;
      if (btn_pulse != 4'b0000) begin
        if (firstPulse < 0) firstPulse = cycleIdx;
        if (nPulse < 16) pulseAt[nPulse] = cycleIdx;
        nPulse++;
      end
      if ($countones(btn_pulse) > 1) multiHot++;
      if (move_valid) begin
        moveCount++;
        if (firstMove < 0) firstMove = cycleIdx;
      end
    end
  endtask

  // Perform one clean press and release that is long enough to debounce.
  task automatic applyStimulus(input logic [3:0] dir);
    clearStats();
    btn = dir;
    runCycles(10);
    btn = 4'b0000;
    runCycles(8);
  endtask

  task automatic doReset();
    reset = 1'b1;
    btn   = 4'b0000;
    runCycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = 4'b0000;
    clearStats();
    runCycles(3);
    compared++;
    if (gate_select !== 5'd1) begin
      mismatched++;
      $display("[TB] FAIL reset_gate: got %0d expected 1", gate_select);
    end
    compared++;
    if (btn_pulse !== 4'b0000 || move_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got pulse %b move %b expected 0000 0", btn_pulse, move_valid);
    end
    reset = 1'b0;
    runCycles(2);
  endtask

  task automatic test_single_press();
    clearStats();
    btn = BtnR;
    runCycles(20);
    compared++;
    if (pulseCount[0] !== 1 || pulseCount[1] + pulseCount[2] + pulseCount[3] !== 0) begin
      mismatched++;
      $display("[TB] FAIL single_pulses: got R=%0d others=%0d expected 1 and 0",
               pulseCount[0], pulseCount[1] + pulseCount[2] + pulseCount[3]);
    end
    compared++;
    if (firstPulse < 6 || firstPulse > 8) begin
      mismatched++;
      $display("[TB] FAIL single_latency: got cycle %0d expected 6..8", firstPulse);
    end
    compared++;
    if (gate_select !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL single_gate: got %0d expected 2", gate_select);
    end
    compared++;
    if (moveCount !== 1 || firstMove !== firstPulse + 1) begin
      mismatched++;
      $display("[TB] FAIL single_move: got count %0d at %0d expected 1 at %0d",
               moveCount, firstMove, firstPulse + 1);
    end
    clearStats();
    btn = 4'b0000;
    runCycles(10);
    compared++;
    if (nPulse !== 0) begin
      mismatched++;
      $display("[TB] FAIL release_no_pulse: got %0d expected 0", nPulse);
    end
  endtask

  task automatic test_bounce();
    clearStats();
    for (int k = 0; k < 15; k++) begin
      btn = (k % 2 == 0) ? BtnR : 4'b0000;
      runCycles(2);
    end
    btn = 4'b0000;
    runCycles(10);
    compared++;
    if (nPulse !== 0 || gate_select !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL bounce: got pulses %0d gate %0d expected 0 and 2", nPulse, gate_select);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] dirs [19];
    int         exps [19];
    int         movs [19];
    dirs = '{BtnR, BtnR, BtnR, BtnR, BtnR, BtnR, BtnR, BtnR, BtnD, BtnL,
             BtnR, BtnD, BtnU, BtnR, BtnR, BtnR, BtnR, BtnD, BtnD};
    exps = '{2, 3, 4, 5, 6, 7, 8, 1, 9, 16, 9, 17, 10, 11, 12, 13, 14, 18, 18};
    movs = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    doReset();
    for (int s = 0; s < 19; s++) begin
      applyStimulus(dirs[s]);
      compared++;
      if (gate_select !== exps[s][4:0] || nPulse !== 1) begin
        mismatched++;
        $display("[TB] FAIL wrap_step%0d: got gate %0d pulses %0d expected %0d and 1",
                 s, gate_select, nPulse, exps[s]);
      end
      compared++;
      if (moveCount !== movs[s]) begin
        mismatched++;
        $display("[TB] FAIL wrap_move%0d: got %0d expected %0d", s, moveCount, movs[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(BtnU);
    applyStimulus(BtnL);
    applyStimulus(BtnL);
    applyStimulus(BtnL);
    compared++;
    if (gate_select !== 5'd12) begin
      mismatched++;
      $display("[TB] FAIL back_to_back_gate: got %0d expected 12", gate_select);
    end
  endtask

  task automatic test_priority();
    applyStimulus(BtnU | BtnL);
    compared++;
    if (pulseCount[3] !== 1 || pulseCount[1] !== 0 || multiHot !== 0) begin
      mismatched++;
      $display("[TB] FAIL priority_pulses: got U=%0d L=%0d multi=%0d expected 1 0 0",
               pulseCount[3], pulseCount[1], multiHot);
    end
    compared++;
    if (gate_select !== 5'd4) begin
      mismatched++;
      $display("[TB] FAIL priority_gate: got %0d expected 4", gate_select);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(BtnR);
    applyStimulus(BtnR);
    applyStimulus(BtnR);
    compared++;
    if (gate_select !== 5'd7) begin
      mismatched++;
      $display("[TB] FAIL resetmid_setup: got %0d expected 7", gate_select);
    end
    btn = BtnR;
    runCycles(3);
    reset = 1'b1;
    clearStats();
    runCycles(2);
    compared++;
    if (gate_select !== 5'd1 || nPulse !== 0 || moveCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL resetmid_during: got gate %0d pulses %0d moves %0d expected 1 0 0",
               gate_select, nPulse, moveCount);
    end
    reset = 1'b0;
    clearStats();
    runCycles(12);
    compared++;
    if (firstPulse < 6 || firstPulse > 8 || nPulse !== 1) begin
      mismatched++;
      $display("[TB] FAIL resetmid_after: got first %0d count %0d expected 6..8 and 1",
               firstPulse, nPulse);
    end
    compared++;
    if (gate_select !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL resetmid_gate: got %0d expected 2", gate_select);
    end
    btn = 4'b0000;
    runCycles(8);
  endtask

  task automatic test_hold();
    doReset();
    clearStats();
    btn = BtnR;
    runCycles(25);
    btn = 4'b0000;
    runCycles(15);
`ifdef GATE_CURSOR_HOLD_REPEAT_EN
    compared++;
    if (nPulse !== 6 || gate_select !== 5'd7 || moveCount !== 6) begin
      mismatched++;
      $display("[TB] FAIL hold_repeat: got pulses %0d gate %0d moves %0d expected 6 7 6",
               nPulse, gate_select, moveCount);
    end
    compared++;
    if (pulseAt[0] !== 7 || pulseAt[1] !== 17 || pulseAt[2] !== 20 ||
        pulseAt[3] !== 23 || pulseAt[4] !== 26 || pulseAt[5] !== 29) begin
      mismatched++;
      $display("[TB] FAIL hold_times: got %0d %0d %0d %0d %0d %0d expected 7 17 20 23 26 29",
               pulseAt[0], pulseAt[1], pulseAt[2], pulseAt[3], pulseAt[4], pulseAt[5]);
    end
`else
    compared++;
    if (nPulse !== 1 || gate_select !== 5'd2 || moveCount !== 1) begin
      mismatched++;
      $display("[TB] FAIL hold_single: got pulses %0d gate %0d moves %0d expected 1 2 1",
               nPulse, gate_select, moveCount);
    end
    compared++;
    if (pulseAt[0] !== 7) begin
      mismatched++;
      $display("[TB] FAIL hold_time: got %0d expected 7", pulseAt[0]);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    btn   = 4'b0000;
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gate_cursor_ctrl.md
GATE_CURSOR_CTRL -- requirements
Module: gate_cursor_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving consecutive stable cycles before a debounced level changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, giving hold cycles before the first auto-repeat; used only with REQ-024.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 20000000, giving cycles between auto-repeats; used only with REQ-024.
REQ-004 SHALL have port clk, input, 1 bit: single system clock (CLK100MHZ domain); every flop is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn, input, 4 bits: raw asynchronous buttons {BTNU, BTND, BTNL, BTNR} in bits [3:0].
REQ-007 SHALL have port btn_pulse, output, 4 bits: one-cycle accepted move pulse per button, same bit order as btn.
REQ-008 SHALL have port gate_select, output, 5 bits: cursor position, legal values 1..18.
REQ-009 SHALL have port move_valid, output, 1 bit: one-cycle strobe indicating gate_select changed.

Function
REQ-010 SHALL pass each btn bit through a two-flop synchronizer before any other logic.
REQ-011 SHALL keep a per-button counter that clears whenever the synchronized level equals the debounced level; the debounced level SHALL flip when the counter reaches DEBOUNCE_CYCLES-1 with the level still differing.
REQ-012 SHALL raise the button's btn_pulse for exactly one cycle in the cycle after its debounced level goes 0->1; a 1->0 transition SHALL give no pulse.
REQ-013 SHALL use only the highest-priority pulse when several occur in one cycle, with priority U > D > L > R; all other pulses that cycle SHALL be dropped and never replayed.
REQ-014 Right SHALL map 8->1, 16->9 and 18->17, and SHALL map every other legal value v to v+1.
REQ-015 Left SHALL map 1->8, 9->16 and 17->18, and SHALL map every other legal value v to v-1.
REQ-016 Up SHALL map 17->10, 18->15 and 9..16 to v-8; values 1..8 SHALL stay unchanged.
REQ-017 Down SHALL map 9..12->17, 13..16->18 and 1..8 to v+8; values 17 and 18 SHALL stay unchanged.
REQ-018 Any accepted pulse while gate_select holds an illegal value (0 or 19..31) SHALL load 1.
REQ-019 SHALL register gate_select on the edge ending the pulse cycle, so the new value is visible the next cycle.
REQ-020 SHALL assert move_valid in that same next cycle only if the value actually changed (e.g. Up at 3 gives no strobe).
REQ-021 Latency from a raw btn edge to btn_pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, +/-1 for synchronizer phase.

Reset
REQ-022 While reset is high, gate_select SHALL load 1, btn_pulse and move_valid SHALL read 0, and synchronizers, debounced levels and all counters SHALL clear.
REQ-023 A button held through the falling edge of reset SHALL give one pulse only after a full debounce interval measured from reset release; no pulse or move from before reset SHALL survive it.

Configuration
REQ-024 With macro GATE_CURSOR_HOLD_REPEAT_EN defined, a debounced-high button SHALL re-pulse REPEAT_DELAY cycles after its first pulse and every REPEAT_PERIOD cycles after that until release.
REQ-025 Repeat pulses SHALL follow REQ-013, and releasing the button SHALL clear its repeat counter.
REQ-026 With GATE_CURSOR_HOLD_REPEAT_EN undefined, exactly one pulse SHALL occur per press, with no repeat logic synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Reset, then BTNR held 20 cycles -> one btn_pulse[0], gate_select 1->2, move_valid one cycle.
REQ-028 BTNR toggling every 2 cycles for 30 cycles -> no pulse, gate_select stays put.
REQ-029 Wrap: 8 presses of R from 1 -> ends at 1; L at 9 -> 16; U at 17 -> 10; D at 14 -> 18; D at 18 -> 18 with no move_valid.
REQ-030 BTNU and BTNL asserted in the same cycle from 12 -> only the U pulse is accepted, gate_select becomes 4.
REQ-031 Reset asserted mid-debounce with gate_select at 7 -> gate_select 1 and no pulse until 4 stable cycles after release.
REQ-032 Macro defined, BTNR held 25 cycles from 1 -> pulses at first accept, +10, +13, +16, +19, +22; gate_select ends at 7.
